// File: rtl/systolic_array_controller.sv
// ----------------------------------------------------------------------------
// systolic_array_controller
//
// Sequencer for an N x N systolic array of int8 processing elements. A start
// request optionally loads a weight matrix (one column per cycle, last column
// first), then streams M activation vectors with per-row skew and drains the
// results out of the bottom of each column. Every output is a combinational
// decode of the registered state and the live stall input.
//
// Ports
//   clk, n_rst     clock, asynchronous active-low reset
//   start          one-cycle job request, honoured only in IDLE
//   num_vectors    M, vectors in the job (sampled with start)
//   keep_weights   reuse resident weights if present (sampled with start)
//   stall          freezes the sequence and blanks all strobes/valids
//   busy, done     job in progress / one-cycle completion pulse
//   load           array-wide weight load control
//   pe_enable      array-wide PE enable
//   weight_rd_en   weight buffer read strobe, weight_col = column being fed
//   act_rd_en      activation buffer read strobe, act_idx = base time index t
//   row_valid      per-row input-valid mask (row r consumes vector t-r)
//   col_valid      per-column output-valid mask, out_valid = OR of col_valid
//   out_idx        vector index of the result at column 0
// ----------------------------------------------------------------------------
module systolic_array_controller #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_vectors,
   input  logic                 keep_weights,
   input  logic                 stall,
   output logic                 busy,
   output logic                 done,
   output logic                 load,
   output logic                 pe_enable,
   output logic                 weight_rd_en,
   output logic [$clog2(N)-1:0] weight_col,
   output logic                 act_rd_en,
   output logic [CNT_W-1:0]     act_idx,
   output logic [N-1:0]         row_valid,
   output logic                 out_valid,
   output logic [N-1:0]         col_valid,
   output logic [CNT_W-1:0]     out_idx
);

   // The counter is one bit wider than the vector count so that the longest
   // job (M = 2^CNT_W - 1 with the largest N) never wraps in the compares.
   localparam int W     = CNT_W + 1;
   localparam int COL_W = $clog2(N);

   localparam logic [W-1:0]     N_W      = W'(N);
   localparam logic [W-1:0]     LAST_K   = W'(N - 1);
   localparam logic [W-1:0]     ACT_OFS  = W'(N - 1);
   localparam logic [W-1:0]     LAST_OFS = W'(2 * N - 2);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_W,
      S_COMPUTE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     cnt_q, cnt_d;       // k in LOAD_W, t in COMPUTE
   logic [CNT_W-1:0] m_q, m_d;
   logic             resident_q, resident_d;

   logic [W-1:0] m_w;
   logic [W-1:0] last_t;
   logic [W-1:0] act_end;
   logic         loading, computing, run;

   assign m_w     = {1'b0, m_q};
   assign last_t  = m_w + LAST_OFS;
   assign act_end = m_w + ACT_OFS;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         m_q        <= '0;
         resident_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         m_q        <= m_d;
         resident_q <= resident_d;
      end
   end

   // NOTE: every signal driven here gets a hold default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      m_d        = m_q;
      resident_d = resident_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d   = num_vectors;
               cnt_d = '0;
               if (num_vectors == '0) begin
                  state_d = S_DONE;
               end else if (keep_weights && resident_q) begin
                  state_d = S_COMPUTE;
               end else begin
                  state_d = S_LOAD_W;
               end
            end
         end
         S_LOAD_W: begin
            if (!stall) begin
               if (cnt_q == LAST_K) begin
                  cnt_d      = '0;
                  resident_d = 1'b1;
                  state_d    = S_COMPUTE;
               end else begin
                  cnt_d = cnt_q + W'(1);
               end
            end
         end
         S_COMPUTE: begin
            if (!stall) begin
               if (cnt_q == last_t) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode. Stall blanks every strobe and valid but leaves busy and
   // the indices alone, so the sequence resumes exactly where it froze.
   always_comb begin
      loading   = (state_q == S_LOAD_W);
      computing = (state_q == S_COMPUTE);
      run       = !stall;

      busy         = loading || computing;
      done         = (state_q == S_DONE);
      pe_enable    = busy && run;
      load         = loading && run;
      weight_rd_en = loading && run;
      weight_col   = loading ? (LAST_COL - cnt_q[COL_W-1:0]) : '0;
      act_rd_en    = computing && run && (cnt_q < act_end);
      act_idx      = computing ? cnt_q[CNT_W-1:0] : '0;
      // Only meaningful while out_valid, where t >= N, so wrapping is harmless.
      out_idx      = computing ? (cnt_q[CNT_W-1:0] - CNT_W'(N)) : '0;

      row_valid = '0;
      col_valid = '0;
      for (int i = 0; i < N; i++) begin
         row_valid[i] = computing && run &&
                        (cnt_q >= W'(i)) && (cnt_q < W'(i) + m_w);
         col_valid[i] = computing && run &&
                        (cnt_q >= N_W + W'(i)) && (cnt_q < N_W + W'(i) + m_w);
      end
      out_valid = |col_valid;
   end

endmodule

// File: tb/tb_systolic_array_controller.sv
// ----------------------------------------------------------------------------
// tb_systolic_array_controller
//
// Directed bench for systolic_array_controller with N = 4, CNT_W = 8. Inputs
// change 1 time unit after the rising edge; outputs are sampled 2 time units
// after it, once the combinational decode has settled.
// ----------------------------------------------------------------------------
module tb_systolic_array_controller;

   localparam int N     = 4;
   localparam int CNT_W = 8;

   logic             clk          = 1'b0;
   logic             n_rst        = 1'b0;
   logic             start        = 1'b0;
   logic [CNT_W-1:0] num_vectors  = '0;
   logic             keep_weights = 1'b0;
   logic             stall        = 1'b0;

   logic             busy, done, load, pe_enable, weight_rd_en;
   logic [1:0]       weight_col;
   logic             act_rd_en;
   logic [CNT_W-1:0] act_idx;
   logic [N-1:0]     row_valid;
   logic             out_valid;
   logic [N-1:0]     col_valid;
   logic [CNT_W-1:0] out_idx;

   int n_checks = 0;
   int n_fails  = 0;

   // Hand-computed per-t patterns for M = 3 (t = 0..9).
   logic [3:0] s1_rv  [10] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0] s1_cv  [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
   logic       s1_ard [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   // Hand-computed per-t patterns for M = 2 (t = 0..8).
   logic [3:0] s2_rv  [9]  = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0] s2_cv  [9]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8};
   logic       s2_ard [9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   systolic_array_controller #(
      .N     (N),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .num_vectors  (num_vectors),
      .keep_weights (keep_weights),
      .stall        (stall),
      .busy         (busy),
      .done         (done),
      .load         (load),
      .pe_enable    (pe_enable),
      .weight_rd_en (weight_rd_en),
      .weight_col   (weight_col),
      .act_rd_en    (act_rd_en),
      .act_idx      (act_idx),
      .row_valid    (row_valid),
      .out_valid    (out_valid),
      .col_valid    (col_valid),
      .out_idx      (out_idx)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/ctl"},
            {busy, done, load, pe_enable, weight_rd_en, act_rd_en, out_valid, weight_col}, '0);
      check({tag, "/idx"}, {act_idx, out_idx, row_valid, col_valid}, '0);
   endtask

   // Presents start for one edge; returns in the first cycle after that edge.
   task automatic pulse_start(input logic [CNT_W-1:0] m, input logic keep, input logic stall_in);
      next_cycle();
      start        = 1'b1;
      num_vectors  = m;
      keep_weights = keep;
      stall        = stall_in;
      next_cycle();
      start        = 1'b0;
      num_vectors  = '0;
      keep_weights = 1'b0;
      stall        = 1'b0;
   endtask

   // M = 3 job that is expected to include the 4-cycle weight load.
   // Optional stall of stall_len cycles at t = stall_t, optional ignored
   // start re-pulse during COMPUTE, optional stall held in IDLE at start.
   task automatic run_s1(input string tag, input logic keep, input int stall_t,
                         input int stall_len, input logic restart, input logic idle_stall);
      pulse_start(8'd3, keep, idle_stall);
      for (int idx = 0; idx < 14; idx++) begin
         if (idx == 4 + stall_t) begin
            for (int s = 0; s < stall_len; s++) begin
               stall = 1'b1;
               #1;
               check({tag, "/stall_busy"}, busy, 1);
               check({tag, "/stall_pe_enable"}, pe_enable, 0);
               check({tag, "/stall_strobes"},
                     {load, weight_rd_en, act_rd_en, out_valid, row_valid, col_valid}, '0);
               check({tag, "/stall_t_hold"}, act_idx, stall_t);
               check({tag, "/stall_done"}, done, 0);
               next_cycle();
            end
            stall = 1'b0;
         end
         start        = restart && (idx == 7);
         num_vectors  = restart ? 8'd1 : 8'd0;
         keep_weights = restart;
         #1;
         check({tag, "/busy"}, busy, 1);
         check({tag, "/pe_enable"}, pe_enable, 1);
         check({tag, "/done"}, done, 0);
         if (idx < 4) begin
            check({tag, "/load"}, {load, weight_rd_en}, 2'b11);
            check({tag, "/weight_col"}, weight_col, 3 - idx);
            check({tag, "/load_quiet"}, {act_rd_en, row_valid, col_valid}, '0);
         end else begin
            check({tag, "/no_load"}, {load, weight_rd_en}, 2'b00);
            check({tag, "/act_idx"}, act_idx, idx - 4);
            check({tag, "/act_rd_en"}, act_rd_en, s1_ard[idx-4]);
            check({tag, "/row_valid"}, row_valid, s1_rv[idx-4]);
            check({tag, "/col_valid"}, col_valid, s1_cv[idx-4]);
            check({tag, "/out_valid"}, out_valid, s1_cv[idx-4] != 4'h0);
            if (s1_cv[idx-4] != 4'h0) check({tag, "/out_idx"}, out_idx, idx - 8);
         end
         next_cycle();
      end
      start        = 1'b0;
      num_vectors  = '0;
      keep_weights = 1'b0;
      #1;
      check({tag, "/done_pulse"}, {done, busy, pe_enable}, 3'b100);
      next_cycle();
      #1;
      check({tag, "/done_once"}, {done, busy}, 2'b00);
   endtask

   initial begin
      int n;

      // Reset state
      #2;
      check_all_zero("reset");
      #10;
      n_rst = 1'b1;
      next_cycle();
      #1;
      check_all_zero("idle");

      // 1: full job with weight load
      run_s1("s1", 1'b0, -1, 0, 1'b0, 1'b0);

      // 2: weights resident, M = 2, no load, 9 busy cycles
      pulse_start(8'd2, 1'b1, 1'b0);
      #1;
      n = 0;
      while (busy && n < 30) begin
         check("s2/no_load", {load, weight_rd_en}, 2'b00);
         if (n < 9) begin
            check("s2/act_idx", act_idx, n);
            check("s2/act_rd_en", act_rd_en, s2_ard[n]);
            check("s2/row_valid", row_valid, s2_rv[n]);
            check("s2/row3", row_valid[3], (n == 3) || (n == 4));
            check("s2/col_valid", col_valid, s2_cv[n]);
         end
         n++;
         next_cycle();
         #1;
      end
      check("s2/busy_cycles", n, 9);
      check("s2/done_pulse", done, 1);

      // 3: stall for 3 cycles at t = 5
      run_s1("s3", 1'b0, 5, 3, 1'b0, 1'b0);

      // 4: M = 0 goes straight to DONE
      pulse_start(8'd0, 1'b0, 1'b0);
      #1;
      check("s4/done", {done, busy, load, pe_enable}, 4'b1000);
      next_cycle();
      #1;
      check("s4/after", {done, busy, load, pe_enable}, 4'b0000);

      // 6: stall in IDLE and a start re-pulse in COMPUTE are both ignored
      next_cycle();
      stall = 1'b1;
      #1;
      check("s6/idle_stall", {busy, pe_enable, done}, 3'b000);
      run_s1("s6", 1'b0, -1, 0, 1'b1, 1'b1);

      // 5: reset mid-job at t = 2, then a keep_weights start must reload
      pulse_start(8'd3, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) next_cycle();
      #1;
      check("s5/pre_reset_t", act_idx, 2);
      n_rst = 1'b0;
      #1;
      check_all_zero("s5/in_reset");
      next_cycle();
      #1;
      check_all_zero("s5/held_reset");
      n_rst = 1'b1;
      run_s1("s5", 1'b1, -1, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
